// File: rtl/lab6_pkg.sv
// Shared LAB6 definitions: sel encodings, word width and the collector state enum.
package lab6_pkg;

    localparam logic [1:0] SEL_LOAD = 2'b00;
    localparam logic [1:0] SEL_3    = 2'b01;
    localparam logic [1:0] SEL_2    = 2'b10;
    localparam logic [1:0] SEL_1    = 2'b11;

    localparam int WORD_W = 8;
    localparam int CNT_W  = 4;

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_t;

endpackage

// File: rtl/beat_size_dec.sv
// Combinational decode of the 2-bit beat mode into a bit count k (8, 3, 2 or 1).
module beat_size_dec
    import lab6_pkg::*;
(
    input  logic [1:0]       sel,
    output logic [CNT_W-1:0] k
);

    always_comb begin
        k = 4'd1;
        unique case (sel)
            SEL_LOAD: k = 4'd8;
            SEL_3:    k = 4'd3;
            SEL_2:    k = 4'd2;
            SEL_1:    k = 4'd1;
        endcase
    end

endmodule

// File: rtl/shift_in_collector.sv
// Serial-to-parallel collector: LSB-first beats of k bits assembled into an 8-bit word.
// Optional sticky mode-change error port under SHIFT_IN_COLLECTOR_ERR_EN.
module shift_in_collector
    import lab6_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        sel,
    input  logic [WORD_W-1:0] din,
    input  logic              din_valid,
    output logic              din_ready,
    output logic [WORD_W-1:0] out,
    output logic              out_valid,
`ifdef SHIFT_IN_COLLECTOR_ERR_EN
    output logic              err,
`endif
    input  logic              out_ready
);

    // Handshakes: a transfer happens on a rising edge where valid && ready.
    // din_ready and out_valid come straight from the state register.

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [WORD_W-1:0] word, word_nxt;
    logic [CNT_W-1:0]  k;
    logic [CNT_W:0]    sum;
    logic              accept;

    beat_size_dec u_dec (
        .sel (sel),
        .k   (k)
    );

    assign din_ready = (state == COLLECT);
    assign out_valid = (state == HOLD);
    assign out       = word;
    assign accept    = din_valid && (state == COLLECT);
    assign sum       = {1'b0, cnt} + {1'b0, k};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= COLLECT;
            cnt   <= '0;
            word  <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            word  <= word_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        word_nxt  = word;
        unique case (state)
            COLLECT: begin
                if (accept) begin
                    // Positions cnt..cnt+k-1 that land inside the word take din[p-cnt];
                    // anything beyond bit 7 simply has no position to land in.
                    for (int p = 0; p < WORD_W; p++) begin
                        logic [2:0] off;
                        off = 3'(p) - cnt[2:0];
                        if ((5'(p) >= {1'b0, cnt}) && (5'(p) < sum))
                            word_nxt[p] = din[off];
                    end
                    if (sum >= 5'd8) begin
                        cnt_nxt   = 4'd8;
                        state_nxt = HOLD;
                    end else begin
                        cnt_nxt = sum[CNT_W-1:0];
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_nxt = COLLECT;
                    cnt_nxt   = '0;
                    word_nxt  = '0;
                end
            end
        endcase
    end

`ifdef SHIFT_IN_COLLECTOR_ERR_EN
    logic [1:0] sel_lat;

    // Mode is pinned by the first beat of a word; any later disagreement is sticky.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_lat <= SEL_LOAD;
            err     <= 1'b0;
        end else if (accept) begin
            if (cnt == '0)
                sel_lat <= sel;
            else if (sel != sel_lat)
                err <= 1'b1;
        end
    end
`endif

endmodule
